// File: rtl/fifo_pkg.sv
// Shared constants for the single-clock FIFO family: default geometry and read-mode encodings.
package fifo_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 3;
  localparam int FIFO_STD   = 0;
  localparam int FIFO_FWFT  = 1;
endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_W register array: synchronous write port, asynchronous read port.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  // Contents are deliberately not reset; occupancy is tracked by the pointers.
  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with standard or first-word-fall-through read,
// programmable almost-full/almost-empty thresholds, flush and overflow/underflow pulses.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int FWFT     = FIFO_STD,
  parameter int AF_LEVEL = (1 << ADDR_W) - 1,
  parameter int AE_LEVEL = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [DATA_W-1:0] buf_in,
  output logic [DATA_W-1:0] buf_out,
  output logic              buf_empty,
  output logic              buf_full,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   fifo_cnt,
  output logic              overflow,
  output logic              underflow
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_CNT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] AF_CNT    = AF_LEVEL[ADDR_W:0];
  localparam logic [ADDR_W:0] AE_CNT    = AE_LEVEL[ADDR_W:0];

  if (!(AE_LEVEL >= 1 && AE_LEVEL < AF_LEVEL && AF_LEVEL <= DEPTH)) begin : g_bad_cfg
    $error("sync_fifo_param: need 1 <= AE_LEVEL < AF_LEVEL <= DEPTH");
  end

  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   cnt;
  logic [DATA_W-1:0] rd_data;
  logic              rd_ok, wr_ok;

  assign buf_empty    = (cnt == '0);
  assign buf_full     = (cnt == DEPTH_CNT);
  assign almost_full  = (cnt >= AF_CNT);
  assign almost_empty = (cnt <= AE_CNT);
  assign fifo_cnt     = cnt;

  // A read frees a slot in the same edge, so a full FIFO may still accept a write.
  assign rd_ok = rd_en & ~buf_empty;
  assign wr_ok = wr_en & (~buf_full | rd_ok);

  fifo_mem #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_ok & rst_n & ~flush),
    .wr_addr (wr_ptr),
    .wr_data (buf_in),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      overflow  <= wr_en & ~wr_ok;
      underflow <= rd_en & ~rd_ok;
    end
  end

  if (FWFT == FIFO_FWFT) begin : g_fwft
    assign buf_out = rd_data;
  end else begin : g_std
    logic [DATA_W-1:0] out_q;
    always_ff @(posedge clk) begin
      if (!rst_n)              out_q <= '0;
      else if (!flush && rd_ok) out_q <= rd_data;
    end
    assign buf_out = out_q;
  end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench: table-driven fill/drain for the default standard-mode FIFO, hand sequences
// for full/empty simultaneous ops, wrap-around, flush, reset and a 16x16 FWFT instance.
module tb_sync_fifo_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default instance: 8-bit, depth 8, standard read, AF=7, AE=1
  logic       rst_n = 1'b0, flush = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
  logic [7:0] buf_in = '0, buf_out;
  logic       buf_empty, buf_full, almost_full, almost_empty, overflow, underflow;
  logic [3:0] fifo_cnt;

  sync_fifo_param dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .rd_en(rd_en),
    .buf_in(buf_in), .buf_out(buf_out), .buf_empty(buf_empty), .buf_full(buf_full),
    .almost_full(almost_full), .almost_empty(almost_empty), .fifo_cnt(fifo_cnt),
    .overflow(overflow), .underflow(underflow)
  );

  // FWFT instance: 16-bit, depth 16, AF=15, AE=1
  logic        f_rst_n = 1'b0, f_flush = 1'b0, f_wr_en = 1'b0, f_rd_en = 1'b0;
  logic [15:0] f_in = '0, f_out;
  logic        f_empty, f_full, f_af, f_ae, f_ovf, f_udf;
  logic [4:0]  f_cnt;

  sync_fifo_param #(.DATA_W(16), .ADDR_W(4), .FWFT(1)) dut_f (
    .clk(clk), .rst_n(f_rst_n), .flush(f_flush), .wr_en(f_wr_en), .rd_en(f_rd_en),
    .buf_in(f_in), .buf_out(f_out), .buf_empty(f_empty), .buf_full(f_full),
    .almost_full(f_af), .almost_empty(f_ae), .fifo_cnt(f_cnt),
    .overflow(f_ovf), .underflow(f_udf)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks count, all four flags (from the default thresholds) and both pulses.
  task automatic chk_stat(input string tag, input int cnt, input bit ovf, input bit udf);
    chk({tag, " cnt"},   32'(fifo_cnt),     32'(cnt));
    chk({tag, " empty"}, 32'(buf_empty),    32'(cnt == 0));
    chk({tag, " full"},  32'(buf_full),     32'(cnt == 8));
    chk({tag, " af"},    32'(almost_full),  32'(cnt >= 7));
    chk({tag, " ae"},    32'(almost_empty), 32'(cnt <= 1));
    chk({tag, " ovf"},   32'(overflow),     32'(ovf));
    chk({tag, " udf"},   32'(underflow),    32'(udf));
  endtask

  task automatic drive(input bit r, input bit f, input bit w, input bit rd, input logic [7:0] d);
    rst_n = r; flush = f; wr_en = w; rd_en = rd; buf_in = d;
  endtask

  typedef struct {
    bit         rst_n, flush, wr, rd;
    logic [7:0] din;
    int         cnt;
    bit         ovf, udf, chk_out;
    logic [7:0] dout;
  } vec_t;

  function automatic vec_t mk(bit r, bit f, bit w, bit rd, logic [7:0] d,
                              int c, bit o, bit u, bit co, logic [7:0] q);
    vec_t v;
    v.rst_n = r; v.flush = f; v.wr = w; v.rd = rd; v.din = d;
    v.cnt = c; v.ovf = o; v.udf = u; v.chk_out = co; v.dout = q;
    return v;
  endfunction

  vec_t vq[$];

  initial begin
    // Reset, fill 1..8, rejected 9th write, drain, underflow, empty simultaneous op
    vq.push_back(mk(0, 0, 0, 0, 8'h00, 0, 0, 0, 1, 8'h00));
    for (int i = 1; i <= 8; i++) vq.push_back(mk(1, 0, 1, 0, 8'(i), i, 0, 0, 1, 8'h00));
    vq.push_back(mk(1, 0, 1, 0, 8'd9, 8, 1, 0, 1, 8'h00));
    vq.push_back(mk(1, 0, 0, 0, 8'h00, 8, 0, 0, 1, 8'h00));
    for (int i = 1; i <= 8; i++) vq.push_back(mk(1, 0, 0, 1, 8'h00, 8 - i, 0, 0, 1, 8'(i)));
    vq.push_back(mk(1, 0, 0, 1, 8'h00, 0, 0, 1, 1, 8'd8));
    vq.push_back(mk(1, 0, 0, 0, 8'h00, 0, 0, 0, 1, 8'd8));
    vq.push_back(mk(1, 0, 1, 1, 8'd2, 1, 0, 1, 1, 8'd8));
    vq.push_back(mk(1, 0, 0, 1, 8'h00, 0, 0, 0, 1, 8'd2));

    tick();
    foreach (vq[i]) begin
      drive(vq[i].rst_n, vq[i].flush, vq[i].wr, vq[i].rd, vq[i].din);
      tick();
      chk_stat($sformatf("vec%0d", i), vq[i].cnt, vq[i].ovf, vq[i].udf);
      if (vq[i].chk_out) chk($sformatf("vec%0d out", i), 32'(buf_out), 32'(vq[i].dout));
    end

    // Full + simultaneous write/read: both accepted, oldest word out, new word read last
    for (int i = 0; i < 8; i++) begin drive(1, 0, 1, 0, 8'(31 + i)); tick(); end
    chk_stat("fullfill", 8, 0, 0);
    drive(1, 0, 1, 1, 8'd140); tick();
    chk_stat("fullsim", 8, 0, 0);
    chk("fullsim out", 32'(buf_out), 32'd31);
    for (int i = 0; i < 8; i++) begin
      drive(1, 0, 0, 1, 8'h00); tick();
      chk($sformatf("fulldrain%0d out", i), 32'(buf_out), (i == 7) ? 32'd140 : 32'(32 + i));
    end
    chk_stat("fulldrain", 0, 0, 0);

    // Wrap-around: 20 write/read pairs, count never above 1
    for (int i = 1; i <= 20; i++) begin
      drive(1, 0, 1, 0, 8'(10 * i)); tick();
      chk($sformatf("wrap%0d cntw", i), 32'(fifo_cnt), 32'd1);
      drive(1, 0, 0, 1, 8'h00); tick();
      chk($sformatf("wrap%0d cntr", i), 32'(fifo_cnt), 32'd0);
      chk($sformatf("wrap%0d out", i), 32'(buf_out), 32'(10 * i));
    end

    // Flush at count 5 with write and read requested: cleared, no pulses, output holds
    for (int i = 0; i < 5; i++) begin drive(1, 0, 1, 0, 8'(1 + i)); tick(); end
    chk_stat("preflush", 5, 0, 0);
    drive(1, 1, 1, 1, 8'd99); tick();
    chk_stat("flush", 0, 0, 0);
    chk("flush out", 32'(buf_out), 32'd200);
    drive(1, 0, 1, 0, 8'd77); tick();
    drive(1, 0, 0, 1, 8'h00); tick();
    chk_stat("postflush", 0, 0, 0);
    chk("postflush out", 32'(buf_out), 32'd77);

    // Flush while full with a write request: no overflow pulse
    for (int i = 0; i < 8; i++) begin drive(1, 0, 1, 0, 8'(50 + i)); tick(); end
    drive(1, 1, 1, 0, 8'd98); tick();
    chk_stat("flushfull", 0, 0, 0);
    drive(1, 0, 0, 0, 8'h00); tick();
    chk_stat("flushfull idle", 0, 0, 0);

    // Reset mid-operation at count 5
    for (int i = 0; i < 6; i++) begin drive(1, 0, 1, 0, 8'(60 + i)); tick(); end
    drive(1, 0, 0, 1, 8'h00); tick();
    chk_stat("prerst", 5, 0, 0);
    chk("prerst out", 32'(buf_out), 32'd60);
    drive(0, 0, 1, 1, 8'd97); tick();
    chk_stat("midrst", 0, 0, 0);
    chk("midrst out", 32'(buf_out), 32'd0);
    drive(1, 0, 0, 0, 8'h00); tick();
    chk_stat("postrst", 0, 0, 0);

    // FWFT instance
    f_rst_n = 1'b1;
    f_wr_en = 1'b1; f_in = 16'hABCD; tick();
    chk("fwft w1 out", 32'(f_out), 32'hABCD);
    chk("fwft w1 empty", 32'(f_empty), 32'd0);
    chk("fwft w1 cnt", 32'(f_cnt), 32'd1);
    f_in = 16'h1234; tick();
    chk("fwft w2 out", 32'(f_out), 32'hABCD);
    chk("fwft w2 ae", 32'(f_ae), 32'd0);
    f_wr_en = 1'b0; f_rd_en = 1'b1; tick();
    chk("fwft r1 out", 32'(f_out), 32'h1234);
    chk("fwft r1 cnt", 32'(f_cnt), 32'd1);
    tick();
    chk("fwft r2 empty", 32'(f_empty), 32'd1);
    chk("fwft r2 udf", 32'(f_udf), 32'd0);
    tick();
    chk("fwft r3 udf", 32'(f_udf), 32'd1);
    f_rd_en = 1'b0; f_wr_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      f_in = 16'(16'h0100 + i); tick();
      chk($sformatf("fwft fill%0d af", i), 32'(f_af), 32'(i + 1 >= 15));
      chk($sformatf("fwft fill%0d full", i), 32'(f_full), 32'(i == 15));
    end
    chk("fwft fill cnt", 32'(f_cnt), 32'd16);
    chk("fwft fill head", 32'(f_out), 32'h0100);
    f_in = 16'hDEAD; tick();
    chk("fwft ovf", 32'(f_ovf), 32'd1);
    chk("fwft ovf head", 32'(f_out), 32'h0100);
    f_wr_en = 1'b0; f_flush = 1'b1; tick();
    chk("fwft flush empty", 32'(f_empty), 32'd1);
    chk("fwft flush ovf", 32'(f_ovf), 32'd0);
    f_flush = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
